// File: rtl/seq_div_unit.sv
// -----------------------------------------------------------------------------
// seq_div_unit
// Multi-cycle restoring divider for the HI/LO datapath. Produces the quotient
// (LO) and remainder (HI) of RegAOut / RegBOut, signed (truncating) or unsigned
// per operation. Normal latency is WIDTH+2 cycles from the start cycle; a zero
// divisor completes in one cycle with div0 raised.
//
// Optional feature macro: SEQ_DIV_EARLY_EXIT_EN
//   When defined, a start whose |dividend| < |divisor| (non-zero divisor)
//   completes in one cycle with LO = 0 and HI = dividend.
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   RegAOut    in   dividend, sampled on the accepting edge
//   RegBOut    in   divisor, sampled on the accepting edge
//   divCtrl    in   start request, accepted only in IDLE
//   signedDiv  in   1 = signed divide, 0 = unsigned, sampled with operands
//   divBusy    out  high while iterating (RUN) and fixing signs (FIX)
//   divDone    out  one-cycle completion pulse
//   div0       out  divide-by-zero flag
//   DivHIOut   out  remainder
//   DivLOOut   out  quotient
// -----------------------------------------------------------------------------
module seq_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] RegAOut,
  input  logic [WIDTH-1:0] RegBOut,
  input  logic             divCtrl,
  input  logic             signedDiv,
  output logic             divBusy,
  output logic             divDone,
  output logic             div0,
  output logic [WIDTH-1:0] DivHIOut,
  output logic [WIDTH-1:0] DivLOOut
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state_r;
  state_t state_nxt_s;

  // Two's-complement negation at operand width.
  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Magnitude of an operand; MIN maps to itself, which is the correct
  // unsigned magnitude 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic             is_signed);
    logic [WIDTH-1:0] m;
    if (is_signed && v[WIDTH-1]) begin
      m = negate(v);
    end else begin
      m = v;
    end
    return m;
  endfunction

  // Operand decode at the accepting edge
  logic             a_neg_s;
  logic             b_neg_s;
  logic [WIDTH-1:0] mag_a_s;
  logic [WIDTH-1:0] mag_b_s;
  logic             b_zero_s;
  logic             early_s;

  assign a_neg_s  = signedDiv & RegAOut[WIDTH-1];
  assign b_neg_s  = signedDiv & RegBOut[WIDTH-1];
  assign mag_a_s  = magnitude(RegAOut, signedDiv);
  assign mag_b_s  = magnitude(RegBOut, signedDiv);
  assign b_zero_s = (RegBOut == {WIDTH{1'b0}});

`ifdef SEQ_DIV_EARLY_EXIT_EN
  assign early_s = ~b_zero_s & (mag_a_s < mag_b_s);
`else
  assign early_s = 1'b0;
`endif

  // Iteration state. rem_r is WIDTH+1 bits so the shifted partial remainder
  // never overflows; quo_r starts as the dividend magnitude and is shifted
  // left, releasing a dividend bit at the top and taking a quotient bit in.
  logic [WIDTH:0]   rem_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] dvs_r;
  logic [CNT_W-1:0] cnt_r;
  logic             neg_q_r;
  logic             neg_r_r;

  logic [WIDTH+1:0] shift_s;
  logic [WIDTH+1:0] diff_s;
  logic             fits_s;

  assign shift_s = {rem_r, quo_r[WIDTH-1]};
  assign diff_s  = shift_s - {2'b00, dvs_r};
  // Top bit set means the trial subtraction went negative (restore).
  assign fits_s  = ~diff_s[WIDTH+1];

  // Registered outputs
  logic             busy_r;
  logic             done_r;
  logic             div0_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;

  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (divCtrl) begin
          if (b_zero_s || early_s) begin
            state_nxt_s = DONE;
          end else begin
            state_nxt_s = RUN;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == CNT_W'(1)) begin
          state_nxt_s = FIX;
        end else begin
          state_nxt_s = RUN;
        end
      end
      FIX:     state_nxt_s = DONE;
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Handshake outputs registered from the next state so they track the FSM
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_nxt_s == RUN) || (state_nxt_s == FIX);
      done_r <= (state_nxt_s == DONE);
    end
  end

  // Divider datapath and result registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rem_r   <= {(WIDTH+1){1'b0}};
      quo_r   <= {WIDTH{1'b0}};
      dvs_r   <= {WIDTH{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
      div0_r  <= 1'b0;
      hi_r    <= {WIDTH{1'b0}};
      lo_r    <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (divCtrl) begin
            if (b_zero_s) begin
              div0_r <= 1'b1;
              hi_r   <= RegAOut;
              lo_r   <= {WIDTH{1'b1}};
            end else if (early_s) begin
              div0_r <= 1'b0;
              hi_r   <= RegAOut;
              lo_r   <= {WIDTH{1'b0}};
            end else begin
              div0_r  <= 1'b0;
              neg_q_r <= a_neg_s ^ b_neg_s;
              neg_r_r <= a_neg_s;
              rem_r   <= {(WIDTH+1){1'b0}};
              quo_r   <= mag_a_s;
              dvs_r   <= mag_b_s;
              cnt_r   <= CNT_W'(WIDTH);
            end
          end
        end
        RUN: begin
          if (fits_s) begin
            rem_r <= diff_s[WIDTH:0];
          end else begin
            rem_r <= shift_s[WIDTH:0];
          end
          quo_r <= {quo_r[WIDTH-2:0], fits_s};
          cnt_r <= cnt_r - CNT_W'(1);
        end
        FIX: begin
          // Truncating division: quotient sign is the XOR of operand signs,
          // remainder takes the dividend's sign.
          lo_r <= neg_q_r ? negate(quo_r) : quo_r;
          hi_r <= neg_r_r ? negate(rem_r[WIDTH-1:0]) : rem_r[WIDTH-1:0];
        end
        DONE: begin
          lo_r <= lo_r;
        end
        default: begin
          lo_r <= lo_r;
        end
      endcase
    end
  end

  assign divBusy  = busy_r;
  assign divDone  = done_r;
  assign div0     = div0_r;
  assign DivHIOut = hi_r;
  assign DivLOOut = lo_r;

endmodule

// File: tb/tb_seq_div_unit.sv
// -----------------------------------------------------------------------------
// tb_seq_div_unit
// Directed self-checking bench for seq_div_unit at WIDTH = 32. Expected
// quotients, remainders and latencies are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_seq_div_unit;

  localparam int W = 32;

`ifdef SEQ_DIV_EARLY_EXIT_EN
  localparam int LAT_SMALL  = 1;
  localparam int BUSY_SMALL = 0;
`else
  localparam int LAT_SMALL  = 34;
  localparam int BUSY_SMALL = 33;
`endif

  logic         clock;
  logic         reset;
  logic [W-1:0] RegAOut;
  logic [W-1:0] RegBOut;
  logic         divCtrl;
  logic         signedDiv;
  logic         divBusy;
  logic         divDone;
  logic         div0;
  logic [W-1:0] DivHIOut;
  logic [W-1:0] DivLOOut;

  int checks = 0;
  int errors = 0;

  seq_div_unit #(.WIDTH(W)) dut (
    .clock    (clock),
    .reset    (reset),
    .RegAOut  (RegAOut),
    .RegBOut  (RegBOut),
    .divCtrl  (divCtrl),
    .signedDiv(signedDiv),
    .divBusy  (divBusy),
    .divDone  (divDone),
    .div0     (div0),
    .DivHIOut (DivHIOut),
    .DivLOOut (DivLOOut)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One division: start, scramble inputs after acceptance, measure latency
  // and busy cycles, then check results and that they hold afterwards.
  task automatic run_div(input string tag,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic toggle,
                         input logic [W-1:0] exp_lo, input logic [W-1:0] exp_hi,
                         input logic exp_div0, input int exp_lat, input int exp_busy);
    int n;
    int nbusy;
    @(posedge clock); #1;
    RegAOut   = a;
    RegBOut   = b;
    signedDiv = s;
    divCtrl   = 1'b1;
    @(posedge clock); #1;
    divCtrl   = 1'b0;
    RegAOut   = ~a;
    RegBOut   = 32'h0000_0000;
    signedDiv = ~s;
    n = 1;
    nbusy = 0;
    while (divDone !== 1'b1 && n < 100) begin
      if (divBusy === 1'b1) nbusy++;
      if (toggle) divCtrl = (n < 20) ? n[0] : 1'b0;
      @(posedge clock); #1;
      n++;
    end
    divCtrl = 1'b0;
    check_eq({tag, " lat"},  64'(n),        64'(exp_lat));
    check_eq({tag, " busy"}, 64'(nbusy),    64'(exp_busy));
    check_eq({tag, " lo"},   64'(DivLOOut), 64'(exp_lo));
    check_eq({tag, " hi"},   64'(DivHIOut), 64'(exp_hi));
    check_eq({tag, " div0"}, 64'(div0),     64'(exp_div0));
    @(posedge clock); #1;
    check_eq({tag, " pulse"},   64'(divDone),  64'(1'b0));
    check_eq({tag, " hold lo"}, 64'(DivLOOut), 64'(exp_lo));
  endtask

  initial begin
    int saw_done;
    reset     = 1'b1;
    RegAOut   = 32'h0000_0000;
    RegBOut   = 32'h0000_0000;
    divCtrl   = 1'b0;
    signedDiv = 1'b0;
    #1;
    check_eq("rst busy", 64'(divBusy),  64'(1'b0));
    check_eq("rst done", 64'(divDone),  64'(1'b0));
    check_eq("rst div0", 64'(div0),     64'(1'b0));
    check_eq("rst hi",   64'(DivHIOut), 64'(32'h0));
    check_eq("rst lo",   64'(DivLOOut), 64'(32'h0));
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;

    // Unsigned basic and sign combinations
    run_div("u100/7", 32'd100, 32'd7, 1'b0, 1'b0, 32'd14, 32'd2, 1'b0, 34, 33);
    run_div("s-7/2",  32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0,
            32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 34, 33);
    run_div("s7/-2",  32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0,
            32'hFFFF_FFFD, 32'd1, 1'b0, 34, 33);
    run_div("s-7/-2", 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, 1'b0,
            32'd3, 32'hFFFF_FFFF, 1'b0, 34, 33);

    // Divide by zero, then div0 cleared by the next valid start
    run_div("div0", 32'h1234_5678, 32'h0, 1'b0, 1'b0,
            32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 1, 0);
    run_div("sovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0,
            32'h8000_0000, 32'h0, 1'b0, 34, 33);
    run_div("uovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0,
            32'h0, 32'h8000_0000, 1'b0, LAT_SMALL, BUSY_SMALL);
    run_div("umax/1", 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0,
            32'hFFFF_FFFF, 32'h0, 1'b0, 34, 33);
    run_div("umax/max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0,
            32'd1, 32'h0, 1'b0, 34, 33);

    // Small dividend (early-exit candidates)
    run_div("u3/10", 32'd3, 32'd10, 1'b0, 1'b0, 32'd0, 32'd3, 1'b0, LAT_SMALL, BUSY_SMALL);
    run_div("s-3/10", 32'hFFFF_FFFD, 32'd10, 1'b1, 1'b0,
            32'd0, 32'hFFFF_FFFD, 1'b0, LAT_SMALL, BUSY_SMALL);

    // divCtrl toggled while running must not disturb the operation
    run_div("toggle", 32'd1000, 32'd10, 1'b0, 1'b1, 32'd100, 32'd0, 1'b0, 34, 33);

    // Reset in the middle of a RUN
    @(posedge clock); #1;
    RegAOut   = 32'd100;
    RegBOut   = 32'd7;
    signedDiv = 1'b0;
    divCtrl   = 1'b1;
    @(posedge clock); #1;
    divCtrl = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    check_eq("mid busy", 64'(divBusy), 64'(1'b1));
    reset = 1'b1;
    #1;
    check_eq("mrst busy", 64'(divBusy),  64'(1'b0));
    check_eq("mrst done", 64'(divDone),  64'(1'b0));
    check_eq("mrst hi",   64'(DivHIOut), 64'(32'h0));
    check_eq("mrst lo",   64'(DivLOOut), 64'(32'h0));
    @(posedge clock); #1;
    reset = 1'b0;
    saw_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock); #1;
      if (divDone === 1'b1 || divBusy === 1'b1) saw_done++;
    end
    check_eq("mrst quiet", 64'(saw_done), 64'(0));
    run_div("u9/3", 32'd9, 32'd3, 1'b0, 1'b0, 32'd3, 32'd0, 1'b0, 34, 33);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_div_unit.md
# seq_div_unit

Parametrised multi-cycle restoring divider for the ALU/HI-LO datapath, producing quotient (LO) and remainder (HI) from the RS/RT operand registers. It succeeds the fixed 32-bit divider with the following additions:
- configurable width;
- per-operation signed/unsigned mode;
- busy/done handshake with a fixed latency;
- defined results on divide-by-zero and signed overflow.

The control unit starts an operation, stalls on `divBusy`, and writes HI/LO when `divDone` pulses.

## Interface
- `WIDTH`, 32, operand/result width in bits; legal range 2 to 64.
- `clock`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `RegAOut`  in  WIDTH  dividend (RS); sampled only on the accepting edge.
- `RegBOut`  in  WIDTH  divisor (RT); sampled only on the accepting edge.
- `divCtrl`  in  1  start request; accepted only in IDLE.
- `signedDiv`  in  1  1 = two's-complement divide (DIV), 0 = unsigned (DIVU); sampled with the operands.
- `divBusy`  out  1  high in RUN and FIX.
- `divDone`  out  1  one-cycle pulse; results valid from this cycle on.
- `div0`  out  1  divide-by-zero flag for the exception logic.
- `DivHIOut`  out  WIDTH  remainder.
- `DivLOOut`  out  WIDTH  quotient.

## Operation
- **States:** IDLE, RUN, FIX, DONE. Reset forces IDLE and sets `divBusy`, `divDone`, `div0`, `DivHIOut` and `DivLOOut` to 0.
- **IDLE, `divCtrl`=1, divisor ≠ 0:**
  - latch signs (only when `signedDiv`=1) and the operand magnitudes;
  - clear partial remainder and quotient, and clear `div0`;
  - load bit counter = WIDTH; go to RUN.
- **IDLE, `divCtrl`=1, divisor = 0:**
  - `div0`=1, `DivHIOut`=RegAOut, `DivLOOut`=all ones;
  - go to DONE (no RUN).
- **RUN:** one restoring step per cycle.
  - Shift the remainder left, bringing in the next dividend MSB.
  - Trial-subtract the divisor magnitude. If the result is non-negative, keep it and set the quotient bit to 1; otherwise the quotient bit is 0.
  - Decrement the counter; at 0, go to FIX.
  - The remainder datapath is WIDTH+1 bits wide, so no overflow is possible.
- **FIX:**
  - Quotient is negated iff the latched signs differ.
  - Remainder is negated iff the latched dividend sign is 1, so the remainder takes the sign of the dividend (truncating division).
  - Register the results into `DivLOOut`/`DivHIOut`; go to DONE.
- **DONE:** `divDone`=1 for exactly this cycle; next state is IDLE. `divCtrl` is ignored here.
- **Signed overflow (MIN / −1):** falls out of the magnitude arithmetic. Result is LO = MIN, HI = 0, `div0`=0, with no special state.
- **Result hold:** `DivHIOut`, `DivLOOut` and `div0` hold until the next accepted start. `div0` clears on a non-zero-divisor start.
- **Start held high:** `divCtrl` asserted during RUN/FIX/DONE is ignored. If it is still high in IDLE, a new operation starts; a level-held `divCtrl` therefore restarts back-to-back.
- **Unsigned mode:** operands are used unmodified; no FIX negation.

## Timing
- **Accept edge E0:** `divCtrl`=1 sampled in IDLE.
- **Normal path:**
  - edges E1..E_WIDTH perform RUN steps;
  - edge E_(WIDTH+1) executes FIX;
  - `divDone` is high in the cycle after E_(WIDTH+1), i.e. WIDTH+2 cycles from the start cycle;
  - `divBusy` is high from after E0 until E_(WIDTH+1).
- **Divide-by-zero:** `divDone` and `div0` are high in the cycle after E0 (latency 1); `divBusy` never asserts.
- **Input stability:** operand and `signedDiv` changes after E0 have no effect.
- **Reset mid-operation:** reset takes effect asynchronously and immediately.
  - FSM goes to IDLE; all outputs go to 0; no `divDone` pulse.
  - The first edge after reset deassertion may accept a start.
- **Minimum interval:** start-to-start is WIDTH+3 cycles (WIDTH+2 for latency, plus 1 IDLE).

## Configuration
- **Macro `SEQ_DIV_EARLY_EXIT_EN`, defined:** at E0, with divisor ≠ 0 and |dividend| < |divisor| in the selected mode:
  - `DivLOOut`=0 and `DivHIOut`=RegAOut (original sign kept), `div0`=0;
  - go directly to DONE, so `divDone` is high in the cycle after E0.
- **Macro undefined:** every non-zero-divisor operation takes the full WIDTH+2 latency, with identical results.

## Test plan
- **Unsigned basic:** WIDTH=32, unsigned, 100 / 7 → LO=14, HI=2, `div0`=0; `divDone` exactly 34 cycles after the start cycle; `divBusy` high for 33 cycles.
- **Signed sign combinations:**
  - −7 / 2 → LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1);
  - 7 / −2 → LO=−3, HI=1;
  - −7 / −2 → LO=3, HI=−1.
- **Divide-by-zero:** 0x12345678 / 0 → `div0`=1, HI=0x12345678, LO=0xFFFFFFFF; `divDone` 1 cycle after start; `div0` cleared by the next valid start.
- **Overflow and mode:**
  - signed 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0, `div0`=0;
  - the same operands unsigned → LO=0, HI=0x80000000.
- **Reset mid-operation:** assert reset 10 cycles into a RUN → outputs 0 and state IDLE immediately, no `divDone`; then 9 / 3 → LO=3, HI=0 at normal latency.
- **Early exit / handshake:** 3 / 10 with `SEQ_DIV_EARLY_EXIT_EN` → LO=0, HI=3, `divDone` after 1 cycle; without the macro, the same result after 34 cycles. `divCtrl` toggled during RUN must not disturb the result.
